// File: rtl/sr_pkg.sv
// Shared types and default widths for the squareroot lane dispatcher.
package sr_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    HOLD = 2'd2
  } lane_state_e;

  localparam int SR_I_WIDTH = 32;
  localparam int SR_NUM     = 16;

  function automatic int sr_o_width(input int i);
    return (i + 1) >> 1;
  endfunction

endpackage

// File: rtl/sr_dispatch_lane.sv
// One lane slot of sr_dispatch: start pulse, operand hold, guard-filtered result capture.
// With SR_DISPATCH_TIMEOUT_EN a watchdog forces a stuck lane to HOLD with an error flag.
module sr_dispatch_lane
  import sr_pkg::*;
#(
  parameter int I_WIDTH = SR_I_WIDTH,
  parameter int O_WIDTH = sr_o_width(SR_I_WIDTH),
  parameter int GUARD   = 1,
  parameter int TIMEOUT = 1024
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               issue,
  input  logic               retire,
  input  logic [I_WIDTH-1:0] s_data,
  input  logic               done,
  input  logic [O_WIDTH-1:0] dout,
  output logic               newd,
  output logic [I_WIDTH-1:0] din,
  output logic               idle,
  output logic               hold,
  output logic               active_nxt,
  output logic [O_WIDTH-1:0] res,
  output logic               err
);

  localparam int GW = (GUARD > 0) ? $clog2(GUARD + 1) : 1;

  lane_state_e   state_q, state_d;
  logic [GW-1:0] guard_q;
  logic          capture;
  logic          expire;

  // done still high from the previous operation is masked until the guard drains
  assign capture = (state_q == BUSY) && done && (guard_q == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (issue) state_d = BUSY;
      BUSY:    if (capture || expire) state_d = HOLD;
      HOLD:    if (retire) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    idle       = (state_q == IDLE);
    hold       = (state_q == HOLD);
    active_nxt = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)               guard_q <= '0;
    else if (issue)           guard_q <= GW'(GUARD);
    else if (guard_q != '0)   guard_q <= guard_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      newd <= 1'b0;
      din  <= '0;
    end else begin
      newd <= issue;
      if (issue) din <= s_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       res <= '0;
    else if (capture) res <= dout;
    else if (expire)  res <= '0;
  end

`ifdef SR_DISPATCH_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT + 1);

  logic [WW-1:0] wd_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                wd_q <= '0;
    else if (issue)            wd_q <= '0;
    else if (state_q == BUSY)  wd_q <= wd_q + 1'b1;
  end

  // a real done in the final watchdog cycle still wins over the forced error
  assign expire = (state_q == BUSY) && !capture && (wd_q == WW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      err <= 1'b0;
    else if (expire) err <= 1'b1;
    else if (retire) err <= 1'b0;
  end
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = TIMEOUT;
  assign expire         = 1'b0;
  assign err            = 1'b0;
`endif

endmodule

// File: rtl/sr_dispatch.sv
// Round-robin issue of radicands to NUM squareroot lanes with in-order result return.
// Optional per-lane watchdog enabled by defining SR_DISPATCH_TIMEOUT_EN.
module sr_dispatch
  import sr_pkg::*;
#(
  parameter int I_WIDTH = SR_I_WIDTH,
  parameter int O_WIDTH = sr_o_width(I_WIDTH),
  parameter int NUM     = SR_NUM,
  parameter int GUARD   = 1,
  parameter int TIMEOUT = 1024
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [I_WIDTH-1:0]       s_data,
  output logic [NUM-1:0]           lane_newd,
  output logic [NUM*I_WIDTH-1:0]   lane_din,
  input  logic [NUM-1:0]           lane_done,
  input  logic [NUM*O_WIDTH-1:0]   lane_dout,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [O_WIDTH-1:0]       m_data,
  output logic [$clog2(NUM)-1:0]   m_lane,
  output logic                     m_err,
  output logic                     busy
);

  localparam int PW = $clog2(NUM);

  logic [PW-1:0]      ip, rp;
  logic [NUM-1:0]     idle, hold, active_nxt, err;
  logic [NUM-1:0]     issue, retire;
  logic [O_WIDTH-1:0] res [NUM];
  logic               s_fire, m_fire;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(NUM - 1)) ? '0 : p + 1'b1;
  endfunction

  // issue looks at the pre-retire state, so a lane retiring this cycle is reissued next cycle
  assign s_ready = en && idle[ip];
  assign s_fire  = s_valid && s_ready;
  assign m_valid = hold[rp];
  assign m_fire  = m_valid && m_ready;
  assign m_data  = res[rp];
  assign m_lane  = rp;
  assign m_err   = err[rp];

  always_comb begin
    issue      = '0;
    retire     = '0;
    issue[ip]  = s_fire;
    retire[rp] = m_fire;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ip   <= '0;
      rp   <= '0;
      busy <= 1'b0;
    end else begin
      if (s_fire) ip <= ptr_inc(ip);
      if (m_fire) rp <= ptr_inc(rp);
      busy <= |active_nxt;
    end
  end

  for (genvar k = 0; k < NUM; k++) begin : g_lane
    sr_dispatch_lane #(
      .I_WIDTH (I_WIDTH),
      .O_WIDTH (O_WIDTH),
      .GUARD   (GUARD),
      .TIMEOUT (TIMEOUT)
    ) u_lane (
      .clk        (clk),
      .rst_n      (rst_n),
      .issue      (issue[k]),
      .retire     (retire[k]),
      .s_data     (s_data),
      .done       (lane_done[k]),
      .dout       (lane_dout[k*O_WIDTH +: O_WIDTH]),
      .newd       (lane_newd[k]),
      .din        (lane_din[k*I_WIDTH +: I_WIDTH]),
      .idle       (idle[k]),
      .hold       (hold[k]),
      .active_nxt (active_nxt[k]),
      .res        (res[k]),
      .err        (err[k])
    );
  end

endmodule

// File: doc/sr_dispatch.md
Name: sr_dispatch

Overview:
- Initiator side of the squareroot lane interface (newd/din out, done/dout back).
- Accepts a stream of radicands on a valid/ready port and issues them round-robin to NUM squareroot lanes.
- Collects each lane's result and returns results in issue order on a valid/ready port.
- Sits between the upstream operand source and the sr_top lane array, in a single clock domain.

Parameters:
- I_WIDTH, 32, radicand width.
- O_WIDTH, (I_WIDTH+1)>>1, root width.
- NUM, 16, number of lanes driven.
- GUARD, 1, cycles after newd during which lane done is ignored.
- TIMEOUT, 1024, watchdog limit in cycles per lane; used only with the optional feature.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous assert, active-low.
- en  in  1  issue enable; retire is unaffected.
- s_valid  in  1  operand valid.
- s_ready  out  1  operand accepted when s_valid && s_ready.
- s_data  in  I_WIDTH  radicand.
- lane_newd  out  NUM  one-cycle start pulse per lane.
- lane_din  out  NUM*I_WIDTH  radicand per lane; lane k occupies bits [k*I_WIDTH +: I_WIDTH].
- lane_done  in  NUM  result-ready level from each lane.
- lane_dout  in  NUM*O_WIDTH  root per lane; packed the same way as lane_din.
- m_valid  out  1  result valid.
- m_ready  in  1  result consumed when m_valid && m_ready.
- m_data  out  O_WIDTH  root.
- m_lane  out  $clog2(NUM)  lane that produced m_data.
- m_err  out  1  timeout flag; tied 0 when the optional feature is absent.
- busy  out  1  at least one lane is non-IDLE.

Behaviour:
- Reset values:
  - All lane states IDLE; issue pointer ip=0; retire pointer rp=0.
  - lane_newd=0, lane_din=0, m_valid=0, m_data=0, m_lane=0, m_err=0, busy=0.
  - Reset mid-operation drops all in-flight work; no results are returned for it.
- Per-lane FSM, states IDLE, BUSY, HOLD:
  - IDLE->BUSY on issue to that lane.
  - BUSY->HOLD when lane_done[k]=1 and the guard has expired; lane_dout[k] is captured into res[k] in that cycle.
  - HOLD->IDLE on retire of that lane.
- Issue:
  - s_ready = en && state[ip]==IDLE (combinational).
  - On handshake: the next cycle has lane_newd[ip]=1 for exactly one cycle and lane_din[ip]=s_data; lane_din holds until the next issue to that lane.
  - ip increments mod NUM after each issue.
  - Guard counter loads GUARD at issue; done is ignored while the guard is nonzero, so stale done from the previous operation is never captured.
- Retire:
  - m_valid = state[rp]==HOLD; m_data = res[rp]; m_lane = rp.
  - m_data and m_lane are stable while m_valid && !m_ready.
  - On handshake, rp increments mod NUM.
  - Results leave strictly in issue order even if a later lane finishes first.
- Full: all lanes non-IDLE -> s_ready=0.
- Empty: state[rp]!=HOLD -> m_valid=0.
- Wrap: ip and rp wrap NUM-1 -> 0. Since ip can only issue to an IDLE lane, ip never overtakes rp.
- Simultaneous retire and issue on the same lane: issue uses the pre-retire state, so that lane is re-issued one cycle later (one-bubble cycle).
- Simultaneous retire of lane a and issue of lane b (a!=b): both take effect in the same cycle.
- Minimum latency, s handshake to m_valid: 1 (newd) + GUARD + lane latency + 1 (capture).
- en=0 blocks new issue; in-flight lanes still complete and retire.
- busy = OR of state[k]!=IDLE, registered.

Optional Feature:
- Macro SR_DISPATCH_TIMEOUT_EN.
- Defined:
  - Each lane has a counter that clears on issue and increments while BUSY.
  - At TIMEOUT the lane is forced to HOLD with res=0 and an err bit set.
  - m_err reflects the err bit of lane rp; the err bit clears on retire.
- Undefined:
  - No counters; m_err is constant 0.
  - A lane that never raises done stalls retire indefinitely.

Decomposition:
- Package sr_pkg:
  - lane_state_e enum (IDLE, BUSY, HOLD).
  - Default widths SR_I_WIDTH=32, SR_NUM=16.
  - Function sr_o_width(i) = (i+1)>>1.
- One sub-module, sr_dispatch_lane, holding the per-lane FSM, guard counter, result register and optional watchdog. It is instantiated NUM times via generate; the top level holds the pointers and muxes.

Test Plan:
- Single op: s_data=16, lane model latency 8 -> lane_newd[0] pulses once; m_valid rises with m_data=4, m_lane=0, m_err=0.
- Values: stream 0, 1, 1000000, 0xFFFFFFFF, m_ready=1 -> results 0, 1, 1000, 0xFFFF in order on lanes 0..3.
- Reorder and full: 16 ops with lane k latency 40-2k, m_ready=0 -> s_ready=0 after the 16th issue; raise m_ready -> results return in order lanes 0..15, then the 17th op issues to lane 0.
- Stale done: lane model holds done=1 for 3 cycles after the previous op -> no early capture; the new root is captured only after done re-asserts.
- Backpressure and reset: m_ready toggled randomly -> m_data stable while stalled; assert rst_n=0 with 5 ops in flight -> all outputs 0 next edge, and the first op after reset uses lane 0.
- With SR_DISPATCH_TIMEOUT_EN and TIMEOUT=64: lane 2 never raises done -> at cycle 64 after issue the lane is forced to HOLD; lane 2's result has m_err=1 and m_data=0; subsequent results have m_err=0.
